// File: rtl/ctrl_idex_pipe.sv
// Decode unit merged with the ID/EX control register of the 5-stage RV32 pipeline.
// Inserts bubbles on hazard/flush and holds ID/EX while a multi-cycle MUL/DIV occupies EX.
module ctrl_idex_pipe #(
  parameter int ENABLE_M = 1,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic       noop_i,
  input  logic       flush_i,
  output logic       ex_valid_o,
  output logic       RegWrite_o,
  output logic       MemtoReg_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       ALUSrc_o,
  output logic       Branch_o,
  output logic [1:0] ALUOp_o,
  output logic [1:0] MulDiv_o,
  output logic       illegal_o,
  output logic       busy_o,
  output logic       md_done_o
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic       ex_valid;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic [1:0] alu_op;
    logic [1:0] mul_div;
    logic       illegal;
  } ctrl_t;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             kill_pend_q, kill_pend_d;
  ctrl_t            ctrl_q, ctrl_d;
  ctrl_t            dec;
  ctrl_t            entry;
  logic             bubble;
  logic             capture;

  // Only funct3[2] matters here (MUL vs DIV class); the low bits belong to the ALU.
  logic unused_funct3;
  assign unused_funct3 = ^funct3_i[1:0];

  always_comb begin
    dec          = '0;
    dec.ex_valid = 1'b1;
    unique case (op_i)
      OP_R: begin
        if (funct7_i == F7_MULDIV && ENABLE_M == 0) begin
          dec.illegal = 1'b1;
        end else begin
          dec.reg_write = 1'b1;
          dec.alu_op    = 2'b10;
          if (funct7_i == F7_MULDIV) dec.mul_div = funct3_i[2] ? 2'b10 : 2'b01;
        end
      end
      OP_I: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.mem_read   = 1'b1;
        dec.alu_src    = 1'b1;
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = 2'b01;
      end
      OP_BRANCH: begin
        dec.branch = 1'b1;
        dec.alu_op = 2'b11;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // kill_pend stands in for a flush that arrived while ID/EX was frozen.
  assign bubble  = !valid_i || noop_i || flush_i || kill_pend_q;
  assign entry   = bubble ? ctrl_t'('0) : dec;
  assign capture = (state_q == IDLE) || (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    kill_pend_d = kill_pend_q;
    ctrl_d      = ctrl_q;
    if (capture) begin
      ctrl_d      = entry;
      kill_pend_d = 1'b0;
      if (entry.mul_div != 2'b00) begin
        state_d = BUSY;
        cnt_d   = funct3_i[2] ? DIV_CNT : MUL_CNT;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end else begin
      cnt_d = cnt_q - 1'b1;
      if (flush_i) kill_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      kill_pend_q <= 1'b0;
      ctrl_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      kill_pend_q <= kill_pend_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign ex_valid_o = ctrl_q.ex_valid;
  assign RegWrite_o = ctrl_q.reg_write;
  assign MemtoReg_o = ctrl_q.mem_to_reg;
  assign MemRead_o  = ctrl_q.mem_read;
  assign MemWrite_o = ctrl_q.mem_write;
  assign ALUSrc_o   = ctrl_q.alu_src;
  assign Branch_o   = ctrl_q.branch;
  assign ALUOp_o    = ctrl_q.alu_op;
  assign MulDiv_o   = ctrl_q.mul_div;
  assign illegal_o  = ctrl_q.illegal;
  assign busy_o     = (state_q == BUSY);
  assign md_done_o  = (state_q == BUSY) && (cnt_q == '0);

endmodule

// File: tb/tb_ctrl_idex_pipe.sv
// Scoreboard bench for ctrl_idex_pipe: expected output vectors are queued as stimulus is driven.
module tb_ctrl_idex_pipe;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       valid_i, valid_m0;
  logic [6:0] op_i;
  logic [2:0] funct3_i;
  logic [6:0] funct7_i;
  logic       noop_i, flush_i;

  logic       ex_valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o;
  logic [1:0] ALUOp_o, MulDiv_o;
  logic       illegal_o, busy_o, md_done_o;

  logic       n_ex_valid, n_RegWrite, n_MemtoReg, n_MemRead, n_MemWrite, n_ALUSrc, n_Branch;
  logic [1:0] n_ALUOp, n_MulDiv;
  logic       n_illegal, n_busy, n_md_done;

  always #5 clk_i = ~clk_i;

  ctrl_idex_pipe #(.ENABLE_M(1), .MUL_LAT(3), .DIV_LAT(8)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .op_i(op_i), .funct3_i(funct3_i),
    .funct7_i(funct7_i), .noop_i(noop_i), .flush_i(flush_i),
    .ex_valid_o(ex_valid_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .ALUSrc_o(ALUSrc_o), .Branch_o(Branch_o),
    .ALUOp_o(ALUOp_o), .MulDiv_o(MulDiv_o), .illegal_o(illegal_o), .busy_o(busy_o),
    .md_done_o(md_done_o)
  );

  ctrl_idex_pipe #(.ENABLE_M(0), .MUL_LAT(3), .DIV_LAT(8)) u_nom (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_m0), .op_i(op_i), .funct3_i(funct3_i),
    .funct7_i(funct7_i), .noop_i(noop_i), .flush_i(flush_i),
    .ex_valid_o(n_ex_valid), .RegWrite_o(n_RegWrite), .MemtoReg_o(n_MemtoReg),
    .MemRead_o(n_MemRead), .MemWrite_o(n_MemWrite), .ALUSrc_o(n_ALUSrc), .Branch_o(n_Branch),
    .ALUOp_o(n_ALUOp), .MulDiv_o(n_MulDiv), .illegal_o(n_illegal), .busy_o(n_busy),
    .md_done_o(n_md_done)
  );

  // Vector order: ex_valid RegWrite MemtoReg MemRead MemWrite ALUSrc Branch ALUOp MulDiv illegal busy md_done
  logic [13:0] obs, obs_nom;
  assign obs = {ex_valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o,
                ALUOp_o, MulDiv_o, illegal_o, busy_o, md_done_o};
  assign obs_nom = {n_ex_valid, n_RegWrite, n_MemtoReg, n_MemRead, n_MemWrite, n_ALUSrc, n_Branch,
                    n_ALUOp, n_MulDiv, n_illegal, n_busy, n_md_done};

  localparam logic [13:0] E_BUB   = 14'b0_0_0_0_0_0_0_00_00_0_0_0;
  localparam logic [13:0] E_ADD   = 14'b1_1_0_0_0_0_0_10_00_0_0_0;
  localparam logic [13:0] E_ADDI  = 14'b1_1_0_0_0_1_0_00_00_0_0_0;
  localparam logic [13:0] E_LW    = 14'b1_1_1_1_0_1_0_00_00_0_0_0;
  localparam logic [13:0] E_SW    = 14'b1_0_0_0_1_1_0_01_00_0_0_0;
  localparam logic [13:0] E_BEQ   = 14'b1_0_0_0_0_0_1_11_00_0_0_0;
  localparam logic [13:0] E_MUL_B = 14'b1_1_0_0_0_0_0_10_01_0_1_0;
  localparam logic [13:0] E_MUL_D = 14'b1_1_0_0_0_0_0_10_01_0_1_1;
  localparam logic [13:0] E_DIV_B = 14'b1_1_0_0_0_0_0_10_10_0_1_0;
  localparam logic [13:0] E_DIV_D = 14'b1_1_0_0_0_0_0_10_10_0_1_1;
  localparam logic [13:0] E_ILL   = 14'b1_0_0_0_0_0_0_00_00_1_0_0;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] F7_M  = 7'b0000001;

  int errors = 0;
  int checks = 0;
  logic [13:0] exp_q[$];
  logic [13:0] exp_nom_q[$];

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic nop, input logic fl);
    valid_i  = v;
    op_i     = op;
    funct3_i = f3;
    funct7_i = f7;
    noop_i   = nop;
    flush_i  = fl;
  endtask

  task automatic test_reset();
    logic [13:0] e;
    rst_i = 1'b0;
    valid_m0 = 1'b0;
    drive(1'b0, 7'd0, 3'd0, 7'd0, 1'b0, 1'b0);
    #1;
    exp_q.push_back(E_BUB);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_init got=%b want=%b", obs, e); end
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, OP_R, 3'b100, F7_M, 1'b0, 1'b0);
      exp_q.push_back(E_DIV_B);
      @(posedge clk_i); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_div_issue cyc%0d got=%b want=%b", i, obs, e); end
    end
    rst_i = 1'b0;
    #1;
    exp_q.push_back(E_BUB);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_async got=%b want=%b", obs, e); end
    exp_q.push_back(E_BUB);
    @(posedge clk_i); #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_held got=%b want=%b", obs, e); end
    rst_i = 1'b1;
    drive(1'b0, OP_R, 3'b100, F7_M, 1'b0, 1'b0);
    exp_q.push_back(E_BUB);
    @(posedge clk_i); #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_idle got=%b want=%b", obs, e); end
    drive(1'b1, OP_R, 3'b000, 7'd0, 1'b0, 1'b0);
    exp_q.push_back(E_ADD);
    @(posedge clk_i); #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_then_add got=%b want=%b", obs, e); end
  endtask

  task automatic test_decode();
    logic [6:0]  ops [6] = '{OP_R, 7'b0010011, 7'b0100011, 7'b1100011, OP_R, 7'b0010011};
    logic [13:0] exps[6] = '{E_ADD, E_ADDI, E_SW, E_BEQ, E_BUB, E_BUB};
    logic        fls [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        vls [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [13:0] e;
    for (int i = 0; i < 6; i++) begin
      drive(vls[i], ops[i], 3'b010, 7'b0100000, 1'b0, fls[i]);
      exp_q.push_back(exps[i]);
      @(posedge clk_i); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL decode idx%0d got=%b want=%b", i, obs, e); end
    end
  endtask

  task automatic test_noop();
    logic [13:0] e;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 7'b0000011, 3'b010, 7'd0, (i == 0), 1'b0);
      exp_q.push_back((i == 0) ? E_BUB : E_LW);
      @(posedge clk_i); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL lw_noop idx%0d got=%b want=%b", i, obs, e); end
    end
  endtask

  task automatic test_mul();
    logic [13:0] e;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       drive(1'b1, OP_R, 3'b000, F7_M, 1'b0, 1'b0);
        1:       drive(1'b1, OP_R, 3'b000, 7'd0, 1'b1, 1'b0);
        2, 3:    drive(1'b1, OP_R, 3'b000, 7'd0, 1'b0, 1'b0);
        default: drive(1'b0, OP_R, 3'b000, 7'd0, 1'b0, 1'b0);
      endcase
      case (i)
        0, 1:    exp_q.push_back(E_MUL_B);
        2:       exp_q.push_back(E_MUL_D);
        3:       exp_q.push_back(E_ADD);
        default: exp_q.push_back(E_BUB);
      endcase
      @(posedge clk_i); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL mul_hold cyc%0d got=%b want=%b", i, obs, e); end
    end
  endtask

  task automatic test_div_flush_back_to_back();
    logic [13:0] e;
    for (int i = 0; i < 26; i++) begin
      drive((i <= 17), OP_R, 3'b100, F7_M, 1'b0, (i == 2));
      if (i == 8 || i == 25)                exp_q.push_back(E_BUB);
      else if (i == 7 || i == 16 || i == 24) exp_q.push_back(E_DIV_D);
      else                                   exp_q.push_back(E_DIV_B);
      @(posedge clk_i); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL div_seq cyc%0d got=%b want=%b", i, obs, e); end
    end
  endtask

  task automatic test_illegal();
    logic [13:0] e, en;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin drive(1'b1, 7'b1111111, 3'b000, 7'd0, 1'b0, 1'b0); valid_m0 = 1'b0; end
        2: begin drive(1'b0, OP_R, 3'b000, F7_M, 1'b0, 1'b0); valid_m0 = 1'b1; end
        default: begin drive(1'b0, OP_R, 3'b000, F7_M, 1'b0, 1'b0); valid_m0 = 1'b0; end
      endcase
      exp_q.push_back((i == 0) ? E_ILL : E_BUB);
      exp_nom_q.push_back((i == 2) ? E_ILL : E_BUB);
      @(posedge clk_i); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL illegal_main cyc%0d got=%b want=%b", i, obs, e); end
      en = exp_nom_q.pop_front(); checks++;
      if (obs_nom !== en) begin errors++; $display("FAIL illegal_nom cyc%0d got=%b want=%b", i, obs_nom, en); end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_noop();
    test_mul();
    test_div_flush_back_to_back();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
